// File: rtl/fp32_pkg.sv
// Shared binary32 definitions: rounding modes, special encodings and field widths.
package fp32_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RNA = 3'd4
    } rmode_e;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

    localparam int unsigned BIAS   = 127;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = 24;
    localparam int unsigned PROD_W = 48;
    localparam int unsigned EXPI_W = 10;

endpackage

// File: rtl/fp_round.sv
// Combinational rounder: applies the mode increment, renormalises a carry-out
// and resolves overflow/underflow into the final exponent and fraction.
module fp_round
    import fp32_pkg::*;
(
    input  logic                     i_sign,
    input  logic [SIG_W-1:0]         i_sig,
    input  logic                     i_g,
    input  logic                     i_r,
    input  logic                     i_s,
    input  logic signed [EXPI_W-1:0] i_exp,
    input  logic [2:0]               i_mode,
    output logic [FRAC_W-1:0]        o_frac,
    output logic [EXP_W-1:0]         o_exp,
    output logic                     o_ovf,
    output logic                     o_udf
);

    logic                     w_inexact;
    logic                     w_inc;
    logic                     w_inf_sel;
    logic [SIG_W:0]           w_sum;
    logic signed [EXPI_W-1:0] w_exp_r;
    logic [FRAC_W-1:0]        w_frac_r;

    // Rounding increment per mode; unknown codes fall back to ties-to-even.
    always_comb begin
        w_inexact = i_g | i_r | i_s;
        w_inc     = 1'b0;
        case (i_mode)
            3'(RTZ): w_inc = 1'b0;
            3'(RDN): w_inc = w_inexact & i_sign;
            3'(RUP): w_inc = w_inexact & ~i_sign;
            3'(RNA): w_inc = i_g;
            default: w_inc = i_g & (i_r | i_s | i_sig[0]);
        endcase
    end

    // Apply increment; a carry out of the significand leaves 1.0 with exponent + 1.
    always_comb begin
        w_sum    = {1'b0, i_sig} + (SIG_W+1)'(w_inc);
        w_exp_r  = i_exp + (w_sum[SIG_W] ? EXPI_W'(1) : EXPI_W'(0));
        w_frac_r = w_sum[SIG_W] ? '0 : w_sum[FRAC_W-1:0];
    end

    // Saturate on overflow (infinity or max finite depending on direction), flush on underflow.
    always_comb begin
        o_ovf     = (w_exp_r >= EXPI_W'(255));
        o_udf     = (w_exp_r <= EXPI_W'(0));
        o_exp     = w_exp_r[EXP_W-1:0];
        o_frac    = w_frac_r;
        w_inf_sel = 1'b1;
        case (i_mode)
            3'(RTZ): w_inf_sel = 1'b0;
            3'(RDN): w_inf_sel = i_sign;
            3'(RUP): w_inf_sel = ~i_sign;
            default: w_inf_sel = 1'b1;
        endcase
        if (o_ovf) begin
            o_exp  = w_inf_sel ? POS_INF[30:23] : MAX_FIN[30:23];
            o_frac = w_inf_sel ? POS_INF[22:0]  : MAX_FIN[22:0];
        end else if (o_udf) begin
            o_exp  = '0;
            o_frac = '0;
        end
    end

endmodule

// File: rtl/fp_mul32_top.sv
// Two-stage binary32 multiplier: stage 1 captures operands and mode,
// stage 2 multiplies, normalises, rounds and registers the result and flags.
module fp_mul32_top
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  r_mode,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf
);

    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [2:0]  r_md;

    logic                     w_sx, w_sy, w_sign;
    logic [EXP_W-1:0]         w_ex, w_ey;
    logic [FRAC_W-1:0]        w_fx, w_fy;
    logic                     w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_x_zero, w_y_zero;
    logic [PROD_W-1:0]        w_prod;
    logic [SIG_W-1:0]         w_sig;
    logic                     w_g, w_r, w_s;
    logic signed [EXPI_W-1:0] w_exp_pre;
    logic [FRAC_W-1:0]        w_rfrac;
    logic [EXP_W-1:0]         w_rexp;
    logic                     w_rovf, w_rudf;
    logic [31:0]              w_z;
    logic                     w_ov, w_ud;

    // Stage 1: register operands together with their rounding mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x  <= '0;
            r_y  <= '0;
            r_md <= '0;
        end else begin
            r_x  <= fp_X;
            r_y  <= fp_Y;
            r_md <= r_mode;
        end
    end

    // Field split and operand class decode; subnormals count as zero.
    always_comb begin
        w_sx     = r_x[31];
        w_sy     = r_y[31];
        w_ex     = r_x[30:23];
        w_ey     = r_y[30:23];
        w_fx     = r_x[22:0];
        w_fy     = r_y[22:0];
        w_sign   = w_sx ^ w_sy;
        w_x_nan  = (&w_ex) & (|w_fx);
        w_y_nan  = (&w_ey) & (|w_fy);
        w_x_inf  = (&w_ex) & ~(|w_fx);
        w_y_inf  = (&w_ey) & ~(|w_fy);
        w_x_zero = ~(|w_ex);
        w_y_zero = ~(|w_ey);
    end

    // Significand product, one-bit normalisation and guard/round/sticky extraction.
    always_comb begin
        w_prod    = PROD_W'({1'b1, w_fx}) * PROD_W'({1'b1, w_fy});
        w_exp_pre = EXPI_W'(w_ex) + EXPI_W'(w_ey) - EXPI_W'(BIAS) + EXPI_W'(w_prod[PROD_W-1]);
        if (w_prod[PROD_W-1]) begin
            w_sig = w_prod[47:24];
            w_g   = w_prod[23];
            w_r   = w_prod[22];
            w_s   = |w_prod[21:0];
        end else begin
            w_sig = w_prod[46:23];
            w_g   = w_prod[22];
            w_r   = w_prod[21];
            w_s   = |w_prod[20:0];
        end
    end

    fp_round u_round (
        .i_sign (w_sign),
        .i_sig  (w_sig),
        .i_g    (w_g),
        .i_r    (w_r),
        .i_s    (w_s),
        .i_exp  (w_exp_pre),
        .i_mode (r_md),
        .o_frac (w_rfrac),
        .o_exp  (w_rexp),
        .o_ovf  (w_rovf),
        .o_udf  (w_rudf)
    );

    // Special-case priority: NaN / inf*0, then infinity, then zero, else rounded product.
    always_comb begin
        w_z  = {w_sign, w_rexp, w_rfrac};
        w_ov = w_rovf;
        w_ud = w_rudf;
        if (w_x_nan || w_y_nan || (w_x_inf && w_y_zero) || (w_y_inf && w_x_zero)) begin
            w_z  = QNAN;
            w_ov = 1'b0;
            w_ud = 1'b0;
        end else if (w_x_inf || w_y_inf) begin
            w_z  = {w_sign, POS_INF[30:0]};
            w_ov = 1'b0;
            w_ud = 1'b0;
        end else if (w_x_zero || w_y_zero) begin
            w_z  = {w_sign, 31'd0};
            w_ov = 1'b0;
            w_ud = 1'b0;
        end
    end

    // Stage 2: register result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fp_Z <= '0;
            ovrf <= 1'b0;
            udrf <= 1'b0;
        end else begin
            fp_Z <= w_z;
            ovrf <= w_ov;
            udrf <= w_ud;
        end
    end

endmodule

// File: tb/tb_fp_mul32_top.sv
// Scoreboard bench for fp_mul32_top: expected results queued at drive time,
// popped and compared when the matching result reaches the output.
module tb_fp_mul32_top;

    logic        clk;
    logic        rst;
    logic [2:0]  r_mode;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;

    typedef struct {
        string       tag;
        logic [31:0] z;
        logic        ov;
        logic        ud;
        bit          tol;
    } sb_entry_t;

    sb_entry_t sb[$];
    bit        s1_v;
    int        n_checks;
    int        n_fail;

    fp_mul32_top dut (
        .clk    (clk),
        .rst    (rst),
        .r_mode (r_mode),
        .fp_X   (fp_X),
        .fp_Y   (fp_Y),
        .fp_Z   (fp_Z),
        .ovrf   (ovrf),
        .udrf   (udrf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report a mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; queue the expectation if valid; compare what emerges after the edge.
    task automatic step(input bit v, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] m, input string tag, input logic [31:0] ez,
                        input logic eo, input logic eu, input bit tol);
        sb_entry_t e;
        bit        out_v;
        logic [31:0] diff;
        fp_X   = x;
        fp_Y   = y;
        r_mode = m;
        if (v) begin
            e.tag = tag; e.z = ez; e.ov = eo; e.ud = eu; e.tol = tol;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        out_v = s1_v;
        s1_v  = v;
        if (out_v) begin
            if (sb.size() == 0) begin
                chk("sb_underrun", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.tol) begin
                    diff = (fp_Z > e.z) ? fp_Z - e.z : e.z - fp_Z;
                    chk({e.tag, "_ulp_gt1"}, {31'd0, (diff > 32'd1)}, 32'd0);
                end else begin
                    chk({e.tag, "_z"}, fp_Z, e.z);
                end
                chk({e.tag, "_ovrf"}, {31'd0, ovrf}, {31'd0, e.ov});
                chk({e.tag, "_udrf"}, {31'd0, udrf}, {31'd0, e.ud});
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 3'd0, "", 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vec(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                       input string tag, input logic [31:0] ez, input logic eo, input logic eu);
        step(1'b1, x, y, m, tag, ez, eo, eu, 1'b0);
    endtask

    // One reset edge with live operands; everything in flight is dropped.
    task automatic do_reset(input string tag);
        rst    = 1'b1;
        fp_X   = 32'h4000_0000;
        fp_Y   = 32'h4040_0000;
        r_mode = 3'd0;
        @(posedge clk);
        #1;
        chk({tag, "_z"}, fp_Z, 32'd0);
        chk({tag, "_ovrf"}, {31'd0, ovrf}, 32'd0);
        chk({tag, "_udrf"}, {31'd0, udrf}, 32'd0);
        sb.delete();
        s1_v = 1'b0;
        rst  = 1'b0;
    endtask

    initial begin
        logic        sx, sy;
        logic [7:0]  ex;
        logic [22:0] fx;
        int          k;
        logic [31:0] x, y, ez;

        n_checks = 0;
        n_fail   = 0;
        s1_v     = 1'b0;
        rst      = 1'b1;
        fp_X     = 32'h3F80_0000;
        fp_Y     = 32'h3F80_0000;
        r_mode   = 3'd0;
        @(posedge clk);
        do_reset("reset_init");

        // Directed vectors, issued back to back.
        vec(32'h4000_0000, 32'h4040_0000, 3'd0, "2x3",       32'h40C0_0000, 1'b0, 1'b0);
        vec(32'h3FC0_0000, 32'h3FC0_0000, 3'd0, "1p5sq",     32'h4010_0000, 1'b0, 1'b0);
        vec(32'h3FC0_0000, 32'h3F80_0001, 3'd0, "tie_rne",   32'h3FC0_0002, 1'b0, 1'b0);
        vec(32'h3FC0_0000, 32'h3F80_0001, 3'd4, "tie_rna",   32'h3FC0_0002, 1'b0, 1'b0);
        vec(32'h3FC0_0000, 32'h3F80_0001, 3'd1, "tie_rtz",   32'h3FC0_0001, 1'b0, 1'b0);
        vec(32'h3FC0_0000, 32'h3F80_0001, 3'd2, "tie_rdn",   32'h3FC0_0001, 1'b0, 1'b0);
        vec(32'hBFC0_0000, 32'h3F80_0001, 3'd2, "tie_rdn_n", 32'hBFC0_0002, 1'b0, 1'b0);
        vec(32'h3FC0_0000, 32'h3F80_0001, 3'd6, "tie_m6",    32'h3FC0_0002, 1'b0, 1'b0);
        vec(32'h3F80_0001, 32'h3F80_0001, 3'd0, "st_rne",    32'h3F80_0002, 1'b0, 1'b0);
        vec(32'h3F80_0001, 32'h3F80_0001, 3'd1, "st_rtz",    32'h3F80_0002, 1'b0, 1'b0);
        vec(32'h3F80_0001, 32'h3F80_0001, 3'd2, "st_rdn",    32'h3F80_0002, 1'b0, 1'b0);
        vec(32'h3F80_0001, 32'h3F80_0001, 3'd3, "st_rup",    32'h3F80_0003, 1'b0, 1'b0);
        vec(32'h7F00_0000, 32'h4000_0000, 3'd0, "ovf_rne",   32'h7F80_0000, 1'b1, 1'b0);
        vec(32'h7F00_0000, 32'h4000_0000, 3'd1, "ovf_rtz",   32'h7F7F_FFFF, 1'b1, 1'b0);
        vec(32'h7F00_0000, 32'h4000_0000, 3'd2, "ovf_rdn_p", 32'h7F7F_FFFF, 1'b1, 1'b0);
        vec(32'hFF00_0000, 32'h4000_0000, 3'd2, "ovf_rdn_n", 32'hFF80_0000, 1'b1, 1'b0);
        vec(32'hFF00_0000, 32'h4000_0000, 3'd3, "ovf_rup_n", 32'hFF7F_FFFF, 1'b1, 1'b0);
        vec(32'h7F00_0000, 32'h4000_0000, 3'd3, "ovf_rup_p", 32'h7F80_0000, 1'b1, 1'b0);
        vec(32'h0080_0000, 32'h3F00_0000, 3'd0, "udf",       32'h0000_0000, 1'b0, 1'b1);
        vec(32'h7F80_0000, 32'h0000_0000, 3'd0, "inf_x_0",   32'h7FC0_0000, 1'b0, 1'b0);
        vec(32'h7FC1_2345, 32'h3F80_0000, 3'd0, "nan_x_1",   32'h7FC0_0000, 1'b0, 1'b0);
        vec(32'hFF80_0000, 32'h4000_0000, 3'd0, "ninf_x_2",  32'hFF80_0000, 1'b0, 1'b0);
        vec(32'h8000_0000, 32'h3F80_0000, 3'd0, "nzero_x_1", 32'h8000_0000, 1'b0, 1'b0);
        vec(32'h3F80_0000, 32'h8000_0001, 3'd0, "subn_zero", 32'h8000_0000, 1'b0, 1'b0);
        step(1'b1, 32'hC5FA_51B2, 32'h4459_8ECA, 3'd1, "mixed_rtz", 32'hCAD4_BADE, 1'b0, 1'b0, 1'b1);

        // Random exact products by powers of two, one per clock.
        for (int i = 0; i < 40; i++) begin
            sx = 1'($urandom_range(0, 1));
            sy = 1'($urandom_range(0, 1));
            ex = 8'($urandom_range(64, 190));
            fx = 23'($urandom);
            k  = int'($urandom_range(0, 40)) - 20;
            x  = {sx, ex, fx};
            y  = {sy, 8'(127 + k), 23'd0};
            ez = {sx ^ sy, 8'(int'(ex) + k), fx};
            vec(x, y, 3'($urandom_range(0, 4)), $sformatf("pow2_%0d", i), ez, 1'b0, 1'b0);
        end

        // Reset mid-stream with an overflowing operation still in flight.
        vec(32'h7F00_0000, 32'h4000_0000, 3'd0, "pre_rst", 32'h7F80_0000, 1'b1, 1'b0);
        vec(32'h7F00_0000, 32'h4000_0000, 3'd0, "dropped", 32'h7F80_0000, 1'b1, 1'b0);
        do_reset("reset_mid");

        vec(32'h4000_0000, 32'h4040_0000, 3'd0, "post_rst", 32'h40C0_0000, 1'b0, 1'b0);
        vec(32'h3FC0_0000, 32'h3FC0_0000, 3'd0, "post_rst2", 32'h4010_0000, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
